// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH valid-tagged registers; 1 cycle per stage, bubbles collapse.
// Backpressure: combinational ready ripple from out_ready; hlt/stall freeze all, flush_mask always applies.
module pipe_stage_chain #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 2,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  v;
  logic [DATA_W-1:0] d [DEPTH];

  logic              frz;
  logic              accept;
  logic [DEPTH:0]    le;
  logic [DEPTH-1:0]  move;
  logic [DEPTH-1:0]  ld;
  logic [DEPTH-1:0]  src_flushed;
  logic [DATA_W-1:0] src_d [DEPTH];

  assign frz      = hlt | stall;
  assign in_ready = le[0] & ~frz;
  assign accept   = in_valid & in_ready;

  // A stage can load when it is empty or its content is leaving this cycle.
  always_comb begin
    le        = '0;
    move      = '0;
    le[DEPTH] = out_ready & ~frz;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      le[i]   = (~v[i] | le[i+1]) & ~frz;
      move[i] = v[i] & le[i+1] & ~frz;
    end
  end

  // Per-stage load source: input port for stage 0, previous stage otherwise.
  always_comb begin
    ld             = '0;
    src_flushed    = '0;
    ld[0]          = accept;
    src_d[0]       = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      ld[i]          = move[i-1];
      src_flushed[i] = flush_mask[i-1];
      src_d[i]       = d[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_mask[i]) begin
          v[i] <= 1'b0;
          if (ZERO_ON_FLUSH) d[i] <= '0;
        end else if (ld[i]) begin
          // A datum leaving a flushed stage dies in transit; destination keeps old data.
          if (src_flushed[i]) begin
            v[i] <= 1'b0;
          end else begin
            v[i] <= 1'b1;
            d[i] <= src_d[i];
          end
        end else if (move[i]) begin
          v[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CNT_W'(v[i]);
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomized and directed bench for pipe_stage_chain (DEPTH=3) with an in-order scoreboard.
module tb_pipe_stage_chain;

  localparam int D  = 3;
  localparam int W  = 32;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hlt = 1'b0;
  logic          stall = 1'b0;
  logic [D-1:0]  flush_mask = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;

  // Reference state: which slots hold a datum and what each slot register holds.
  logic         mv [D];
  logic [W-1:0] md [D];
  logic [W-1:0] exp_q [$];

  pipe_stage_chain #(.DATA_W(W), .DEPTH(D), .ZERO_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt), .stall(stall), .flush_mask(flush_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic q_remove(input logic [W-1:0] val);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k] == val) begin
        exp_q.delete(k);
        break;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    exp_q.delete();
  endtask

  // Compare current outputs against the model, then advance the model by one clock.
  task automatic check_and_model();
    int           occ;
    logic         frz, acc, oxf, hole, found;
    logic         adv [D];
    logic         nv [D];
    logic [W-1:0] nd [D];
    frz = hlt | stall;
    occ = 0;
    for (int i = 0; i < D; i++) occ += int'(mv[i]);
    chk("out_valid", out_valid, mv[D-1]);
    chk("out_data",  out_data,  md[D-1]);
    chk("occupancy", occupancy, occ);
    chk("in_ready",  in_ready,  !frz && (occ < D || out_ready));

    // A datum advances when anything downstream of it can make room.
    for (int i = 0; i < D; i++) begin
      hole = out_ready;
      for (int j = i + 1; j < D; j++) if (!mv[j]) hole = 1'b1;
      adv[i] = !frz && mv[i] && hole;
    end
    acc = in_valid && !frz && (occ < D || out_ready);
    oxf = !frz && mv[D-1] && out_ready;

    for (int i = 0; i < D; i++) begin
      nv[i] = mv[i];
      nd[i] = md[i];
    end
    for (int i = 0; i < D; i++) if (adv[i]) nv[i] = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      if (adv[i]) begin
        nv[i+1] = 1'b1;
        nd[i+1] = md[i];
      end
    end
    if (acc) begin
      nv[0] = 1'b1;
      nd[0] = in_data;
    end
    for (int i = 0; i < D; i++) begin
      if (flush_mask[i]) begin
        nv[i] = 1'b0;
        nd[i] = '0;
        if (i < D - 1 && adv[i] && !flush_mask[i+1]) begin
          nv[i+1] = 1'b0;
          nd[i+1] = md[i+1];
        end
      end
    end

    for (int i = 0; i < D; i++) begin
      if (mv[i] && !(i == D - 1 && oxf)) begin
        found = 1'b0;
        for (int j = 0; j < D; j++) if (nv[j] && nd[j] == md[i]) found = 1'b1;
        if (!found) q_remove(md[i]);
      end
    end
    if (acc && !flush_mask[0]) exp_q.push_back(in_data);

    for (int i = 0; i < D; i++) begin
      mv[i] = nv[i];
      md[i] = nd[i];
    end
  endtask

  task automatic step(input logic iv, input logic [W-1:0] idat, input logic ordy,
                      input logic h, input logic s, input logic [D-1:0] fm);
    in_valid   = iv;
    in_data    = idat;
    out_ready  = ordy;
    hlt        = h;
    stall      = s;
    flush_mask = fm;
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, ordy, 1'b0, 1'b0, '0);
  endtask

  // Output monitor: every real transfer must deliver the oldest live datum.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !hlt && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h, expected no transfer", out_data);
      end else begin
        chk("out_order", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data",  out_data,  0);
    chk("reset_occupancy", occupancy, 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full throughput.
    step(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'hA1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, '0);
    idle(4, 1'b1);

    // Back-pressure: fourth word waits until one cycle of out_ready.
    step(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hB3, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hB3, 1'b1, 1'b0, 1'b0, '0);
    chk("bp_occupancy", occupancy, 3);
    idle(5, 1'b1);

    // Bubble collapse from v=[1,0,1].
    step(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, '0);
    idle(2, 1'b0);
    step(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0, '0);
    chk("bubble_occupancy", occupancy, 3);

    // Freeze via hlt then via stall, with the downstream ready.
    for (int k = 0; k < 4; k++) step(1'b1, 32'hD0, 1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) step(1'b1, 32'hD0, 1'b1, 1'b0, 1'b1, '0);
    idle(4, 1'b1);

    // Flush of stages 0 and 1 while stage 2 transfers out.
    step(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hE1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hE2, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hE3, 1'b1, 1'b0, 1'b0, 3'b011);
    chk("flush_occupancy", occupancy, 0);
    idle(2, 1'b1);

    // Asynchronous reset between edges with two words in flight.
    step(1'b1, 32'hF0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hF1, 1'b0, 1'b0, 1'b0, '0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data",  out_data,  0);
    chk("arst_occupancy", occupancy, 0);
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, '0);
    idle(D + 1, 1'b1);

    // Randomized traffic with freezes and flushes.
    for (int k = 0; k < 2000; k++) begin
      logic [W-1:0] dat;
      logic [D-1:0] fm;
      seq++;
      dat = {4'hC, seq[11:0], 16'($urandom)};
      fm  = ($urandom % 8 == 0) ? D'($urandom) : '0;
      step($urandom % 4 != 0, dat, $urandom % 3 != 0,
           $urandom % 10 == 0, $urandom % 10 == 0, fm);
    end

    idle(D + 2, 1'b1);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, elastic successor to the fixed MEM/WB-style pipeline register.
- A chain of DEPTH valid-tagged data stages with a valid/ready handshake at both ends; bubbles collapse.
- Global halt/stall freeze; per-stage flush mask; occupancy output.
- Used between CPU/sprite pipeline stages wherever more than one register slot or back-pressure is needed.

Parameters:
- DATA_W, 32, payload width in bits (1..256).
- DEPTH, 2, number of register stages (1..8); stage 0 is input side, stage DEPTH-1 drives the output.
- ZERO_ON_FLUSH, 1, when 1 a flushed or reset stage's data is forced to 0; when 0 only its valid bit clears.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- hlt  input  1  global halt: freezes every stage.
- stall  input  1  hazard stall: same freeze as hlt, separate for debug visibility.
- flush_mask  input  DEPTH  bit i set invalidates stage i next cycle.
- in_valid  input  1  upstream has data.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  chain accepts in_data this cycle.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_data  output  DATA_W  stage DEPTH-1 payload.
- out_ready  input  1  downstream consumes this cycle.
- occupancy  output  CNT_W  count of valid stages.

Behaviour:
- State: v[i], d[i] for i in 0..DEPTH-1.
- Reset (async, any time, including mid-transfer): all v = 0, all d = 0. Outputs after reset: out_valid=0, out_data=0, occupancy=0. in_ready=1 once rst_n is high, unless hlt or stall is asserted.
- frz = hlt | stall.
- Load-enable chain (combinational, no registered ready):
  - le[DEPTH] = out_ready.
  - le[i] = !v[i] | le[i+1].
  - move[i] = v[i] & le[i+1].
  - All terms are forced to 0 when frz.
- in_ready = le[0] & !frz. Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready & !frz.
- Per clock, when not frozen:
  - Stage i (i>0) loads d[i-1] with v[i]=1 when move[i-1].
  - Stage 0 loads in_data when accept.
  - Otherwise v[i] = v[i] & !move[i], and d holds.
  - Latency: 1 cycle per stage when unblocked; a datum reaches out_valid DEPTH cycles after accept into an empty chain. Full throughput is 1 per cycle.
  - Bubbles collapse: an empty stage always accepts from upstream even while the output is blocked.
- Freeze (frz=1): no stage changes and in_ready=0. out_valid and out_data hold; a downstream out_ready is not a transfer. flush_mask still applies.
- Flush (highest priority after reset, applies regardless of frz):
  - Every stage with flush_mask[i]=1 has v[i]=0 next cycle, plus d[i]=0 if ZERO_ON_FLUSH.
  - Any datum moving into a flushed stage that cycle is dropped.
  - Data moving out of a flushed stage into an unflushed stage is also dropped: the destination gets v=0, d unchanged.
  - An output transfer with flush_mask[DEPTH-1]=1 still completes; the downstream took it.
  - An input accepted while flush_mask[0]=1 is dropped; in_ready is not affected by flush_mask.
- occupancy = popcount(v), registered state only (reflects current cycle, not next).
- Full: all v=1 and out_ready=0 gives in_ready=0. Empty: out_valid=0, occupancy=0.
- in_data/out_data are passed bit-exact; no width conversion.

Test Plan:
- DEPTH=3, DATA_W=32, out_ready=1: accept 0xA0,0xA1,0xA2 on cycles 0..2 -> out_valid on cycles 3..5 with 0xA0,0xA1,0xA2. in_ready stays 1 and occupancy peaks at 3.
- Back-pressure with out_ready=0: push 4 words -> first 3 accepted, in_ready=0 on the 4th, occupancy=3. Raise out_ready for 1 cycle -> 0xA0 leaves, in_ready=1 in the same cycle, the 4th word is accepted and occupancy stays 3.
- Bubble collapse: with v=[1,0,1] (stage0..2) and out_ready=0, present input -> next state v=[1,1,1] and stage1 holds the old stage0 data.
- Freeze: full chain, out_ready=1, hlt=1 for 4 cycles -> no state change, out_data constant, in_ready=0. Repeat with stall instead of hlt -> identical response.
- Flush: full chain, flush_mask=3'b011, in_valid=1, out_ready=1 -> output transfer of stage2 completes and the input is dropped. Next cycle occupancy=0, d[0]=d[1]=0 (ZERO_ON_FLUSH=1).
- Reset mid-operation: assert rst_n=0 asynchronously between edges with occupancy=2 -> out_valid=0, out_data=0, occupancy=0 immediately. After release, the first accepted word emerges after DEPTH cycles.
